// File: rtl/pack_arb_pkg.sv
// Shared definitions for the two-source packet arbiter.
//   - arb_state_t     : arbiter FSM states
//   - calc_pack_bytes : bytes delivered per packet (packet bytes minus preamble)
//   - header layout   : {source id (1 bit), sequence number (7 bits)}
//   - TIMEOUT_CYCLES  : stall limit, only used when PACK_ARB_TIMEOUT_EN is defined
package pack_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2,
      PAD     = 2'd3
   } arb_state_t;

   localparam int SIZE_BIT_PACK_DEF       = 1976;
   localparam int SIZE_INPUT_BIT_DEF      = 8;
   localparam int SIZE_PREAMBLE_BYTES_DEF = 4;

   localparam logic [7:0] FILL_BYTE_DEF = 8'h00;

   localparam int HDR_ID_W  = 1;
   localparam int HDR_SEQ_W = 7;

   localparam int TIMEOUT_CYCLES = 64;

   function automatic int calc_pack_bytes(input int bits_pack, input int bits_in,
                                          input int preamble_bytes);
      return (bits_pack / bits_in) - preamble_bytes;
   endfunction

   localparam int PACK_BYTES_DEF =
      calc_pack_bytes(SIZE_BIT_PACK_DEF, SIZE_INPUT_BIT_DEF, SIZE_PREAMBLE_BYTES_DEF);

endpackage

// File: rtl/rr_select_2.sv
// Two-way round-robin pick, purely combinational.
// Ports:
//   i_ptr      preferred source when both request
//   i_valid_0  source 0 request
//   i_valid_1  source 1 request
//   o_any      at least one source requests
//   o_pick     index of the chosen source (meaningful only when o_any)
module rr_select_2 (
   input  logic i_ptr,
   input  logic i_valid_0,
   input  logic i_valid_1,
   output logic o_any,
   output logic o_pick
);

   always_comb begin
      o_any = i_valid_0 | i_valid_1;
      if (i_valid_0 && i_valid_1) begin
         o_pick = i_ptr;
      end else begin
         o_pick = i_valid_1;
      end
   end

endmodule

// File: rtl/pack_arbiter.sv
// Packet-granular round-robin arbiter sharing the assembler byte input
// between two byte sources. Each packet is one header byte {id, seq},
// then payload from the granted source, then fill bytes if the source
// frame ended early, always PACK_BYTES bytes in total.
//
// Optional feature macro: PACK_ARB_TIMEOUT_EN
//   When defined, a PAYLOAD stall of TIMEOUT_CYCLES consecutive cycles
//   without source valid closes the frame as if i_last had been seen.
//
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_data_k/i_valid_k/i_last_k/o_ready_k   source k byte stream (k = 0,1)
//   o_data/o_valid/i_ready    byte stream to the assembler
//   o_sop                     high while the header byte is presented
//   o_grant                   one-hot current owner, 00 when idle
//   o_pkt_count               completed packets, wrapping
//
// States:
//   IDLE    | no owner; arbitrate among valid sources
//   HEADER  | present {grant_id, seq} header byte
//   PAYLOAD | pass granted source straight through
//   PAD     | present FILL_BYTE until the packet is full
module pack_arbiter
   import pack_arb_pkg::*;
#(
   parameter int                        SIZE_BIT_PACK       = SIZE_BIT_PACK_DEF,
   parameter int                        SIZE_INPUT_BIT      = SIZE_INPUT_BIT_DEF,
   parameter int                        SIZE_PREAMBLE_BYTES = SIZE_PREAMBLE_BYTES_DEF,
   parameter logic [SIZE_INPUT_BIT-1:0] FILL_BYTE           = FILL_BYTE_DEF
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [SIZE_INPUT_BIT-1:0] i_data_0,
   input  logic                      i_valid_0,
   input  logic                      i_last_0,
   output logic                      o_ready_0,
   input  logic [SIZE_INPUT_BIT-1:0] i_data_1,
   input  logic                      i_valid_1,
   input  logic                      i_last_1,
   output logic                      o_ready_1,
   output logic [SIZE_INPUT_BIT-1:0] o_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_sop,
   output logic [1:0]                o_grant,
   output logic [15:0]               o_pkt_count
);

   localparam int PACK_BYTES = calc_pack_bytes(SIZE_BIT_PACK, SIZE_INPUT_BIT,
                                                SIZE_PREAMBLE_BYTES);
   localparam int CNT_W = $clog2(PACK_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACK_BYTES);

   arb_state_t           state_q, state_d;
   logic                 grant_id_q, grant_id_d;
   logic [1:0]           grant_q, grant_d;
   logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d, byte_cnt_inc;
   logic                 rr_ptr_q, rr_ptr_d;
   logic [HDR_SEQ_W-1:0] seq0_q, seq0_d, seq1_q, seq1_d, hdr_seq;
   logic [15:0]          pkt_cnt_q, pkt_cnt_d;
   logic                 pkt_done;

   logic                      src_valid, src_last;
   logic [SIZE_INPUT_BIT-1:0] src_data;

   logic pick_any, pick_id;

`ifdef PACK_ARB_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   logic [TMR_W-1:0] stall_tmr_q, stall_tmr_d;
`endif

   rr_select_2 u_rr_select (
      .i_ptr     (rr_ptr_q),
      .i_valid_0 (i_valid_0),
      .i_valid_1 (i_valid_1),
      .o_any     (pick_any),
      .o_pick    (pick_id)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= IDLE;
         grant_id_q  <= 1'b0;
         grant_q     <= 2'b00;
         byte_cnt_q  <= '0;
         rr_ptr_q    <= 1'b0;
         seq0_q      <= '0;
         seq1_q      <= '0;
         pkt_cnt_q   <= '0;
`ifdef PACK_ARB_TIMEOUT_EN
         stall_tmr_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         grant_q     <= grant_d;
         byte_cnt_q  <= byte_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         seq0_q      <= seq0_d;
         seq1_q      <= seq1_d;
         pkt_cnt_q   <= pkt_cnt_d;
`ifdef PACK_ARB_TIMEOUT_EN
         stall_tmr_q <= stall_tmr_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      grant_d      = grant_q;
      byte_cnt_d   = byte_cnt_q;
      rr_ptr_d     = rr_ptr_q;
      seq0_d       = seq0_q;
      seq1_d       = seq1_q;
      pkt_cnt_d    = pkt_cnt_q;
      pkt_done     = 1'b0;
      o_data       = '0;
      o_valid      = 1'b0;
      o_sop        = 1'b0;
      o_ready_0    = 1'b0;
      o_ready_1    = 1'b0;
      byte_cnt_inc = byte_cnt_q + 1'b1;
`ifdef PACK_ARB_TIMEOUT_EN
      stall_tmr_d  = stall_tmr_q;
`endif

      src_data  = grant_id_q ? i_data_1  : i_data_0;
      src_valid = grant_id_q ? i_valid_1 : i_valid_0;
      src_last  = grant_id_q ? i_last_1  : i_last_0;
      hdr_seq   = grant_id_q ? seq1_q    : seq0_q;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_id_d = pick_id;
               grant_d    = pick_id ? 2'b10 : 2'b01;
               byte_cnt_d = '0;
               state_d    = HEADER;
            end
         end

         HEADER: begin
            o_data  = SIZE_INPUT_BIT'({grant_id_q, hdr_seq});
            o_valid = 1'b1;
            o_sop   = 1'b1;
            if (i_ready) begin
               byte_cnt_d = byte_cnt_inc;
               state_d    = PAYLOAD;
`ifdef PACK_ARB_TIMEOUT_EN
               stall_tmr_d = TMR_LOAD;
`endif
            end
         end

         PAYLOAD: begin
            o_data  = src_data;
            o_valid = src_valid;
            if (grant_id_q) begin
               o_ready_1 = i_ready;
            end else begin
               o_ready_0 = i_ready;
            end
            if (src_valid && i_ready) begin
               byte_cnt_d = byte_cnt_inc;
               // A full packet wins over i_last: the frame end on the final
               // slot needs no padding, and the next packet starts fresh.
               if (byte_cnt_inc == LAST_CNT) begin
                  pkt_done = 1'b1;
               end else if (src_last) begin
                  state_d = PAD;
               end
`ifdef PACK_ARB_TIMEOUT_EN
               stall_tmr_d = TMR_LOAD;
`endif
            end
`ifdef PACK_ARB_TIMEOUT_EN
            else if (!src_valid) begin
               if (stall_tmr_q == '0) begin
                  state_d = PAD;
               end else begin
                  stall_tmr_d = stall_tmr_q - 1'b1;
               end
            end
`endif
         end

         PAD: begin
            o_data  = FILL_BYTE;
            o_valid = 1'b1;
            if (i_ready) begin
               byte_cnt_d = byte_cnt_inc;
               if (byte_cnt_inc == LAST_CNT) begin
                  pkt_done = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (pkt_done) begin
         state_d   = IDLE;
         rr_ptr_d  = ~grant_id_q;
         grant_d   = 2'b00;
         pkt_cnt_d = pkt_cnt_q + 16'd1;
         if (grant_id_q) begin
            seq1_d = seq1_q + 1'b1;
         end else begin
            seq0_d = seq0_q + 1'b1;
         end
      end
   end

   assign o_grant     = grant_q;
   assign o_pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_pack_arbiter.sv
// Scoreboard bench for pack_arbiter: stimulus tasks queue source bytes and
// the hand-computed expected output bytes; a monitor pops and compares on
// every assembler-side transfer.
module tb_pack_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic [7:0]  i_data_0 = 8'h00, i_data_1 = 8'h00;
   logic        i_valid_0 = 1'b0, i_valid_1 = 1'b0;
   logic        i_last_0 = 1'b0, i_last_1 = 1'b0;
   logic        i_ready = 1'b1;
   logic        o_ready_0, o_ready_1;
   logic [7:0]  o_data;
   logic        o_valid, o_sop;
   logic [1:0]  o_grant;
   logic [15:0] o_pkt_count;

   pack_arbiter dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_data_0    (i_data_0),
      .i_valid_0   (i_valid_0),
      .i_last_0    (i_last_0),
      .o_ready_0   (o_ready_0),
      .i_data_1    (i_data_1),
      .i_valid_1   (i_valid_1),
      .i_last_1    (i_last_1),
      .o_ready_1   (o_ready_1),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_sop       (o_sop),
      .o_grant     (o_grant),
      .o_pkt_count (o_pkt_count)
   );

   always #5 i_clk = ~i_clk;

   int          total = 0;
   int          bad = 0;
   logic [10:0] exp_q[$];     // {grant, sop, data}
   logic [8:0]  src_q0[$];    // {last, data}
   logic [8:0]  src_q1[$];
   int          src_idx0 = 0, src_idx1 = 0;
   int          cyc = 0, xfer_cnt = 0;
   int          sop_cyc[$];
   int          xfer_cyc[$];
   logic        x0 = 1'b0, x1 = 1'b0;
   logic        rand_rdy = 1'b0;
   logic        hold_q = 1'b0;
   logic [7:0]  hold_data = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] val(input int k, input int idx);
      logic [6:0] lo;
      lo = 7'((idx % 127) + 1);
      return {k[0], lo};
   endfunction

   function automatic logic [1:0] gnt(input int k);
      return (k == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic send_frame(input int k, input int n, input bit with_last, output int st);
      logic [8:0] b;
      st = (k == 1) ? src_idx1 : src_idx0;
      for (int i = 0; i < n; i++) begin
         b = {(with_last && (i == n - 1)), val(k, st + i)};
         if (k == 1) src_q1.push_back(b);
         else        src_q0.push_back(b);
      end
      if (k == 1) src_idx1 += n;
      else        src_idx0 += n;
   endtask

   task automatic exp_hdr(input int k, input int seq);
      logic [6:0] s;
      s = 7'(seq);
      exp_q.push_back({gnt(k), 1'b1, k[0], s});
   endtask

   task automatic exp_bytes(input int k, input int st, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({gnt(k), 1'b0, val(k, st + i)});
   endtask

   task automatic exp_fill(input int k, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({gnt(k), 1'b0, 8'h00});
   endtask

   task automatic do_reset();
      @(posedge i_clk); #2;
      i_reset_n = 1'b0;
      src_q0.delete(); src_q1.delete(); exp_q.delete();
      sop_cyc.delete(); xfer_cyc.delete();
      src_idx0 = 0; src_idx1 = 0; rand_rdy = 1'b0; xfer_cnt = 0;
      repeat (3) @(posedge i_clk);
      #2;
      check("reset_outputs",
            {2'b00, o_data, o_valid, o_sop, o_grant, o_ready_0, o_ready_1, o_pkt_count}, 0);
      i_reset_n = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || o_valid || o_grant != 2'b00) && n < 20000) begin
         @(posedge i_clk); #2;
         n++;
      end
      total++;
      if (n >= 20000) begin
         bad++;
         $display("FAIL %s_drain: timeout with %0d bytes still expected", name, exp_q.size());
      end
      repeat (2) @(posedge i_clk);
      #2;
   endtask

   // monitor / scoreboard
   initial forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_reset_n) begin
         x0 = 1'b0; x1 = 1'b0; hold_q = 1'b0;
      end else begin
         x0 = i_valid_0 && o_ready_0;
         x1 = i_valid_1 && o_ready_1;
         if (hold_q && o_valid) check("hold_stable", {24'd0, o_data}, {24'd0, hold_data});
         if (o_grant == 2'b01)      check("nongrant_ready1", {31'd0, o_ready_1}, 0);
         else if (o_grant == 2'b10) check("nongrant_ready0", {31'd0, o_ready_0}, 0);
         if (o_valid && i_ready) begin
            xfer_cnt++;
            xfer_cyc.push_back(cyc);
            if (o_sop) sop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_byte: got %0h expected none", {o_grant, o_sop, o_data});
            end else begin
               check("out_byte", {21'd0, o_grant, o_sop, o_data}, {21'd0, exp_q.pop_front()});
            end
         end
         hold_q = o_valid && !i_ready;
         hold_data = o_data;
      end
   end

   // source and ready driver
   initial forever begin
      @(posedge i_clk);
      #1;
      if (x0 && src_q0.size() > 0) src_q0.delete(0);
      if (x1 && src_q1.size() > 0) src_q1.delete(0);
      if (src_q0.size() > 0) begin
         i_valid_0 = 1'b1; {i_last_0, i_data_0} = src_q0[0];
      end else begin
         i_valid_0 = 1'b0; i_last_0 = 1'b0; i_data_0 = 8'h00;
      end
      if (src_q1.size() > 0) begin
         i_valid_1 = 1'b1; {i_last_1, i_data_1} = src_q1[0];
      end else begin
         i_valid_1 = 1'b0; i_last_1 = 1'b0; i_data_1 = 8'h00;
      end
      i_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, n;

      // both sources valid from reset: grants 0,1,0,1, headers 00,80,01,81
      do_reset();
      send_frame(0, 5, 1, st); send_frame(0, 5, 1, st);
      send_frame(1, 5, 1, st); send_frame(1, 5, 1, st);
      exp_hdr(0, 0); exp_bytes(0, 0, 5); exp_fill(0, 237);
      exp_hdr(1, 0); exp_bytes(1, 0, 5); exp_fill(1, 237);
      exp_hdr(0, 1); exp_bytes(0, 5, 5); exp_fill(0, 237);
      exp_hdr(1, 1); exp_bytes(1, 5, 5); exp_fill(1, 237);
      wait_drain("alt");
      check("alt_pkt_count", {16'd0, o_pkt_count}, 4);

      // source 0 only, 300-byte frame: split into 242 + 58 with padding
      do_reset();
      send_frame(0, 300, 1, st);
      exp_hdr(0, 0); exp_bytes(0, 0, 242);
      exp_hdr(0, 1); exp_bytes(0, 242, 58); exp_fill(0, 184);
      wait_drain("split");
      check("split_pkt_count", {16'd0, o_pkt_count}, 2);
      check("split_sops", sop_cyc.size(), 2);
      if (sop_cyc.size() >= 2) check("split_cadence", sop_cyc[1] - sop_cyc[0], 244);

      // exact fit: i_last on the 242nd payload byte, no PAD
      do_reset();
      send_frame(0, 242, 1, st); send_frame(0, 3, 1, st);
      exp_hdr(0, 0); exp_bytes(0, 0, 242);
      exp_hdr(0, 1); exp_bytes(0, 242, 3); exp_fill(0, 239);
      wait_drain("exact");
      check("exact_pkt_count", {16'd0, o_pkt_count}, 2);
      check("exact_sops", sop_cyc.size(), 2);
      if (sop_cyc.size() >= 2) check("exact_cadence", sop_cyc[1] - sop_cyc[0], 244);

      // random assembler backpressure
      do_reset();
      rand_rdy = 1'b1;
      send_frame(0, 20, 1, st); send_frame(0, 250, 1, st);
      send_frame(1, 30, 1, st);
      exp_hdr(0, 0); exp_bytes(0, 0, 20);   exp_fill(0, 222);
      exp_hdr(1, 0); exp_bytes(1, 0, 30);   exp_fill(1, 212);
      exp_hdr(0, 1); exp_bytes(0, 20, 242);
      exp_hdr(0, 2); exp_bytes(0, 262, 8);  exp_fill(0, 234);
      wait_drain("rand");
      rand_rdy = 1'b0;
      check("rand_pkt_count", {16'd0, o_pkt_count}, 4);
      check("rand_xfers", xfer_cnt, 4 * 243);
      repeat (2) @(posedge i_clk);
      #2;

      // reset after byte 100 of a packet (source 0 sequence is now 3)
      xfer_cnt = 0;
      send_frame(0, 200, 1, st);
      exp_hdr(0, 3); exp_bytes(0, st, 99);
      n = 0;
      while (xfer_cnt < 100 && n < 5000) begin
         @(posedge i_clk); #2;
         n++;
      end
      check("midpkt_reached", {31'd0, (n < 5000)}, 1);
      i_reset_n = 1'b0;
      #1;
      check("midpkt_reset_outputs",
            {2'b00, o_data, o_valid, o_sop, o_grant, o_ready_0, o_ready_1, o_pkt_count}, 0);
      check("midpkt_sb_empty", exp_q.size(), 0);
      src_q0.delete(); src_q1.delete(); exp_q.delete();
      repeat (2) @(posedge i_clk);
      #2;
      i_reset_n = 1'b1;
      #1;
      check("count_after_reset", {16'd0, o_pkt_count}, 0);
      send_frame(0, 10, 1, st);
      exp_hdr(0, 0); exp_bytes(0, st, 10); exp_fill(0, 232);
      wait_drain("post_reset");
      check("post_reset_pkt_count", {16'd0, o_pkt_count}, 1);

`ifdef PACK_ARB_TIMEOUT_EN
      // source 1 stalls after 10 bytes; 64 idle cycles, then PAD
      do_reset();
      send_frame(1, 10, 0, st);
      exp_hdr(1, 0); exp_bytes(1, 0, 10); exp_fill(1, 232);
      wait_drain("timeout");
      check("timeout_pkt_count", {16'd0, o_pkt_count}, 1);
      check("timeout_xfers", xfer_cyc.size(), 243);
      if (xfer_cyc.size() >= 12) check("timeout_gap", xfer_cyc[11] - xfer_cyc[10], 65);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
